axi_stream_checker: RTL and testbench

Parametrised AXI4-Stream sink that captures a burst of `DEPTH` beats into an internal buffer and checks each beat against an arithmetic pattern, `SEED + index*STRIDE`. Valid-to-ready backpressure is programmable, and it also checks TLAST placement. It produces pass/fail, an error count and the first failing index. It replaces hand-written buffer checks in stream benches and sits directly on the slave side of an `axi_stream_if`-style link in simulation or FPGA self-test builds.

---
 rtl/axi_stream_checker.sv | 130 +++++++++++++
 tb/tb_axi_stream_checker.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_checker.sv
// AXI4-Stream sink that captures a DEPTH-beat burst, checks it against SEED + i*STRIDE
// and TLAST placement, and exposes the captured buffer through a registered read port.
module axi_stream_checker #(
    parameter int          DATA_WIDTH    = 32,
    parameter int          DEPTH         = 8,
    parameter logic [31:0] SEED          = 32'hDEADBEEF,
    parameter logic [31:0] STRIDE        = 32'd1,
    parameter logic [7:0]  READY_PATTERN = 8'hFF,
    parameter bit          CHECK_LAST    = 1'b1
) (
    input  logic                          aclk,
    input  logic                          areset_n,
    input  logic                          start,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic                          s_tvalid,
    input  logic                          s_tlast,
    output logic                          s_tready,
    input  logic [$clog2(DEPTH)-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [7:0]                    err_count,
    output logic [$clog2(DEPTH):0]        first_err_idx,
    output logic [$clog2(DEPTH):0]        beat_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRIES = 1 << AW;

    localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]         LAST_C   = CW'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] SEED_W   = DATA_WIDTH'(SEED);
    localparam logic [DATA_WIDTH-1:0] STRIDE_W = DATA_WIDTH'(STRIDE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [2:0]              phase;
    logic [DATA_WIDTH-1:0]   exp_acc;
    logic [DATA_WIDTH-1:0]   mem [ENTRIES];

    logic                    arm;
    logic                    accept;
    logic                    last_idx;
    logic                    data_err;
    logic                    last_err;
    logic                    finish;
    logic [8:0]              err_sum;
    logic [7:0]              err_next;

    // tready is a function of registered state only, so no input-to-output path exists
    assign s_tready = (state == RECV) && READY_PATTERN[phase];
    assign busy     = (state == RECV);
    assign done     = (state == DONE);
    assign pass     = done && (err_count == 8'd0) && (beat_count == DEPTH_C);

    assign accept   = s_tvalid && s_tready;
    assign last_idx = (beat_count == LAST_C);
    assign data_err = (s_tdata != exp_acc);
    assign last_err = CHECK_LAST && (s_tlast != last_idx);
    assign finish   = accept && (last_idx || (CHECK_LAST && s_tlast));

    assign err_sum  = {1'b0, err_count} + {8'b0, data_err} + {8'b0, last_err};
    assign err_next = err_sum[8] ? 8'hFF : err_sum[7:0];

    always_ff @(posedge aclk) begin
        if (!areset_n) state <= IDLE;
        else           state <= state_n;
    end

    always_comb begin
        state_n = state;
        arm     = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = RECV;
                arm     = 1'b1;
            end
            RECV: if (finish) state_n = DONE;
            DONE: if (start) begin
                state_n = RECV;
                arm     = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            phase         <= 3'd0;
            exp_acc       <= SEED_W;
            err_count     <= 8'd0;
            beat_count    <= '0;
            first_err_idx <= '1;
        end else if (arm) begin
            phase         <= 3'd0;
            exp_acc       <= SEED_W;
            err_count     <= 8'd0;
            beat_count    <= '0;
            first_err_idx <= '1;
        end else if (state == RECV) begin
            phase <= phase + 3'd1;
            if (accept) begin
                beat_count <= beat_count + 1'b1;
                exp_acc    <= exp_acc + STRIDE_W;
                err_count  <= err_next;
                // all ones marks "no error yet"; it can never be a real beat index
                if ((first_err_idx == '1) && (data_err || last_err))
                    first_err_idx <= beat_count;
            end
        end
    end

    // Buffer is deliberately not reset or cleared on re-arm
    always_ff @(posedge aclk) begin
        if (accept) mem[beat_count[AW-1:0]] <= s_tdata;
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) rd_data <= '0;
        else           rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_axi_stream_checker.sv
// Self-checking bench for axi_stream_checker: vector table, randomized bursts against a
// spec-level model, and hand sequences for backpressure, wrap/re-arm and mid-burst reset.
module tb_axi_stream_checker;

    logic aclk;
    logic areset_n;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // default-parameter instance
    logic        start, s_tvalid, s_tlast, s_tready, busy, done, pass;
    logic [31:0] s_tdata, rd_data;
    logic [2:0]  rd_addr;
    logic [7:0]  err_count;
    logic [3:0]  first_err_idx, beat_count;

    axi_stream_checker dut (
        .aclk(aclk), .areset_n(areset_n), .start(start),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx), .beat_count(beat_count)
    );

    // backpressure instance
    logic        start_b, tvalid_b, tlast_b, tready_b, busy_b, done_b, pass_b;
    logic [31:0] tdata_b, rd_data_b;
    logic [2:0]  rd_addr_b;
    logic [7:0]  err_b;
    logic [3:0]  first_b, beat_b;

    axi_stream_checker #(.READY_PATTERN(8'b0101_0101)) dut_bp (
        .aclk(aclk), .areset_n(areset_n), .start(start_b),
        .s_tdata(tdata_b), .s_tvalid(tvalid_b), .s_tlast(tlast_b), .s_tready(tready_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_err_idx(first_b), .beat_count(beat_b)
    );

    // 16-bit wrap instance
    logic        start_w, tvalid_w, tlast_w, tready_w, busy_w, done_w, pass_w;
    logic [15:0] tdata_w, rd_data_w;
    logic [1:0]  rd_addr_w;
    logic [7:0]  err_w;
    logic [2:0]  first_w, beat_w;

    axi_stream_checker #(.DATA_WIDTH(16), .DEPTH(4), .SEED(32'h0000FFFE), .STRIDE(32'd1)) dut_w (
        .aclk(aclk), .areset_n(areset_n), .start(start_w),
        .s_tdata(tdata_w), .s_tvalid(tvalid_w), .s_tlast(tlast_w), .s_tready(tready_w),
        .rd_addr(rd_addr_w), .rd_data(rd_data_w), .busy(busy_w), .done(done_w), .pass(pass_w),
        .err_count(err_w), .first_err_idx(first_w), .beat_count(beat_w)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] beat_data [8];
    logic        beat_last [8];
    logic [31:0] rd_after  [8];
    logic [15:0] wdata     [4];
    logic        wlast     [4];

    typedef struct {
        int corrupt;
        int lastpos;
        int exp_err;
        int exp_first;
        int exp_beats;
        bit exp_pass;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l, output bit ok);
        bit r;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            r = s_tready;
            tick();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        s_tvalid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push handshake: got no tready expected acceptance");
        end
    endtask

    task automatic arm();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int n, input bit gaps);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (!busy) break;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) tick();
            end
            push(beat_data[i], beat_last[i], ok);
            rd_after[i] = rd_data;
            if (!ok) break;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        for (int c = 0; c < 20 && !done; c++) tick();
    endtask

    task automatic push_w(input logic [15:0] d, input logic l);
        bit r, ok;
        tdata_w  = d;
        tlast_w  = l;
        tvalid_w = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            r = tready_w;
            tick();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        tvalid_w = 1'b0;
        tlast_w  = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wrap push handshake: got no tready expected acceptance");
        end
    endtask

    task automatic send_w();
        for (int i = 0; i < 4; i++) begin
            if (!busy_w) break;
            push_w(wdata[i], wlast[i]);
        end
        for (int c = 0; c < 20 && !done_w; c++) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        areset_n = 1'b0;
        start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; rd_addr = '0;
        start_b = 1'b0; tvalid_b = 1'b0; tlast_b = 1'b0; tdata_b = '0; rd_addr_b = '0;
        start_w = 1'b0; tvalid_w = 1'b0; tlast_w = 1'b0; tdata_w = '0; rd_addr_w = '0;

        tbl[0] = '{-1, 7, 0, 15, 8, 1'b1};
        tbl[1] = '{ 3, 7, 1,  3, 8, 1'b0};
        tbl[2] = '{-1, 5, 1,  5, 6, 1'b0};
        tbl[3] = '{-1, 8, 1,  7, 8, 1'b0};
        tbl[4] = '{ 5, 5, 2,  5, 6, 1'b0};
        tbl[5] = '{ 0, 7, 1,  0, 8, 1'b0};
        tbl[6] = '{-1, 0, 1,  0, 1, 1'b0};
        tbl[7] = '{ 7, 8, 2,  7, 8, 1'b0};

        repeat (3) tick();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset pass", pass, 0);
        chk("reset tready", s_tready, 0);
        chk("reset err", err_count, 0);
        chk("reset beats", beat_count, 0);
        chk("reset first", first_err_idx, 4'hF);
        chk("reset rd_data", rd_data, 0);
        chk("reset wrap first", first_w, 3'h7);
        areset_n = 1'b1;
        tick();

        // tvalid outside RECV is ignored
        s_tvalid = 1'b1;
        s_tdata  = 32'h1234_5678;
        repeat (3) tick();
        chk("idle tready", s_tready, 0);
        chk("idle beats", beat_count, 0);
        s_tvalid = 1'b0;

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 8; i++) begin
                beat_data[i] = 32'hDEADBEEF + 32'(i);
                beat_last[i] = (i == tbl[t].lastpos);
                if (i == tbl[t].corrupt) beat_data[i] = 32'h0;
            end
            rd_addr = (t == 1) ? 3'd3 : 3'd0;
            arm();
            if (t == 0) begin
                chk("start latency busy", busy, 1);
                chk("start latency tready", s_tready, 1);
            end
            send(8, 1'b0);
            chk($sformatf("t%0d done", t), done, 1);
            chk($sformatf("t%0d pass", t), pass, tbl[t].exp_pass);
            chk($sformatf("t%0d err", t), err_count, tbl[t].exp_err);
            chk($sformatf("t%0d first", t), first_err_idx, tbl[t].exp_first);
            chk($sformatf("t%0d beats", t), beat_count, tbl[t].exp_beats);

            // further valid beats after done must not be taken
            s_tvalid = 1'b1;
            s_tdata  = 32'h0BAD_0BAD;
            repeat (3) tick();
            s_tvalid = 1'b0;
            chk($sformatf("t%0d hold tready", t), s_tready, 0);
            chk($sformatf("t%0d hold beats", t), beat_count, tbl[t].exp_beats);
            chk($sformatf("t%0d hold done", t), done, 1);

            if (t == 0) begin
                for (int a = 0; a < 8; a++) begin
                    rd_addr = 3'(a);
                    tick();
                    chk($sformatf("t0 rd[%0d]", a), rd_data, 32'hDEADBEEF + 32'(a));
                end
            end
            if (t == 1) begin
                chk("rd old on same-cycle write", rd_after[3], 32'hDEADBEF2);
                chk("rd corrupted beat", rd_data, 32'h0);
            end
        end

        // randomized bursts against a rule-level model
        for (int it = 0; it < 30; it++) begin
            int lastpos, m_cnt, m_err, m_first, j;
            bit de, le, m_pass;
            logic [31:0] e;
            lastpos = $urandom_range(0, 9);
            for (int i = 0; i < 8; i++) begin
                beat_data[i] = ($urandom_range(0, 5) == 0) ? $urandom : 32'hDEADBEEF + 32'(i);
                beat_last[i] = (lastpos < 8) ? (i == lastpos) : (lastpos == 8 && i == 7);
            end
            m_cnt = 0; m_err = 0; m_first = 15;
            for (int i = 0; i < 8; i++) begin
                e  = 32'(64'h0DEADBEEF + 64'(i) * 64'd1);
                de = (beat_data[i] != e);
                le = (beat_last[i] != (i == 7));
                m_err += int'(de) + int'(le);
                if ((de || le) && m_first == 15) m_first = i;
                m_cnt = i + 1;
                if (i == 7 || beat_last[i]) break;
            end
            if (m_err > 255) m_err = 255;
            m_pass = (m_err == 0) && (m_cnt == 8);
            arm();
            send(8, 1'b1);
            chk($sformatf("r%0d done", it), done, 1);
            chk($sformatf("r%0d pass", it), pass, m_pass);
            chk($sformatf("r%0d err", it), err_count, m_err);
            chk($sformatf("r%0d first", it), first_err_idx, m_first);
            chk($sformatf("r%0d beats", it), beat_count, m_cnt);
            j = $urandom_range(0, m_cnt - 1);
            rd_addr = 3'(j);
            tick();
            chk($sformatf("r%0d rd[%0d]", it, j), rd_data, beat_data[j]);
        end

        // backpressure: alternating ready, source always valid
        begin
            int cyc, k, prev, first_acc, gap_bad;
            bit r;
            tdata_b  = 32'hDEADBEEF;
            tlast_b  = 1'b0;
            tvalid_b = 1'b1;
            tick();
            chk("bp idle tready", tready_b, 0);
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            cyc = 0; k = 0; prev = 0; first_acc = 0; gap_bad = 0;
            while (!done_b && cyc < 64) begin
                r = tready_b;
                tick();
                cyc++;
                if (r) begin
                    if (k == 0) first_acc = cyc;
                    else if (cyc - prev != 2) gap_bad++;
                    prev = cyc;
                    k++;
                    tdata_b = 32'hDEADBEEF + 32'(k);
                    tlast_b = (k == 7);
                end
            end
            tvalid_b = 1'b0;
            tlast_b  = 1'b0;
            chk("bp done", done_b, 1);
            chk("bp first accept cycle", first_acc, 1);
            chk("bp accepted beats", k, 8);
            chk("bp irregular gaps", gap_bad, 0);
            chk("bp done latency in 15..17", (cyc >= 15 && cyc <= 17), 1);
            chk("bp pass", pass_b, 1);
            chk("bp beats", beat_b, 8);
        end

        // 16-bit wrap-around, then an erroring burst, then re-arm
        wdata[0] = 16'hFFFE; wdata[1] = 16'hFFFF; wdata[2] = 16'h0000; wdata[3] = 16'h0001;
        for (int i = 0; i < 4; i++) wlast[i] = (i == 3);
        start_w = 1'b1; tick(); start_w = 1'b0;
        send_w();
        chk("wrap done", done_w, 1);
        chk("wrap pass", pass_w, 1);
        chk("wrap err", err_w, 0);
        chk("wrap beats", beat_w, 4);
        rd_addr_w = 2'd2;
        tick();
        chk("wrap rd[2]", rd_data_w, 16'h0000);

        wdata[2] = 16'h1234;
        start_w = 1'b1; tick(); start_w = 1'b0;
        send_w();
        chk("wrap bad pass", pass_w, 0);
        chk("wrap bad err", err_w, 1);
        chk("wrap bad first", first_w, 2);

        wdata[2] = 16'h0000;
        start_w = 1'b1; tick(); start_w = 1'b0;
        chk("rearm busy", busy_w, 1);
        chk("rearm done", done_w, 0);
        chk("rearm err", err_w, 0);
        chk("rearm beats", beat_w, 0);
        chk("rearm first", first_w, 3'h7);
        send_w();
        chk("rearm pass", pass_w, 1);

        // reset in the middle of a burst
        for (int i = 0; i < 8; i++) begin
            beat_data[i] = 32'hDEADBEEF + 32'(i);
            beat_last[i] = (i == 7);
        end
        beat_data[1] = 32'h0;
        arm();
        send(3, 1'b0);
        areset_n = 1'b0;
        tick();
        chk("mid reset busy", busy, 0);
        chk("mid reset done", done, 0);
        chk("mid reset pass", pass, 0);
        chk("mid reset tready", s_tready, 0);
        chk("mid reset err", err_count, 0);
        chk("mid reset beats", beat_count, 0);
        chk("mid reset first", first_err_idx, 4'hF);
        chk("mid reset rd_data", rd_data, 0);
        areset_n = 1'b1;
        tick();
        beat_data[1] = 32'hDEADBEF0;
        arm();
        send(8, 1'b0);
        chk("post reset done", done, 1);
        chk("post reset pass", pass, 1);
        chk("post reset beats", beat_count, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
